// File: rtl/dmem_pkg.sv
// Shared funct3 encodings, access sizes and lane helpers for the data-memory LSU.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    function automatic logic [3:0] be_mask(input size_e size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001;
            SZ_H:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m << lane;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] funct3);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (funct3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_BU:   return {24'b0, sh[7:0]};
            F3_HU:   return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// DEPTH x 32 byte-enabled synchronous RAM; read-before-write, no reset.
module dmem_sram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// RV32I data memory with load/store formatting and a one-slot response stage.
// DMEM_OUTREG_EN adds a second output register (2-cycle latency, 1/cycle throughput).
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    size_e       size;
    logic        f3_bad, misal, oor, err, accept, s1_go;
    logic [3:0]  be;
    logic [31:0] wdata_rep, sram_rdata, s1_data;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_err_q, s1_err_d;
    logic        s1_load_q, s1_load_d;
    logic [1:0]  s1_lane_q, s1_lane_d;
    logic [2:0]  s1_f3_q, s1_f3_d;

    always_comb begin
        size   = SZ_W;
        f3_bad = 1'b0;
        case (req_funct3_i[1:0])
            2'b00:   size = SZ_B;
            2'b01:   size = SZ_H;
            2'b10:   size = SZ_W;
            default: f3_bad = 1'b1;
        endcase
        // Unsigned variants exist only for loads, and never for words.
        if (req_funct3_i[2] && (req_we_i || req_funct3_i[1])) f3_bad = 1'b1;
        misal = ((size == SZ_H) && req_addr_i[0]) || ((size == SZ_W) && (req_addr_i[1:0] != 2'b00));
        oor   = 32'(req_addr_i[ADDR_W-1:2]) >= 32'(DEPTH);
        err   = f3_bad || misal || oor;
        be    = (req_we_i && !err) ? be_mask(size, req_addr_i[1:0]) : '0;
        case (size)
            SZ_B:    wdata_rep = {4{req_wdata_i[7:0]}};
            SZ_H:    wdata_rep = {2{req_wdata_i[15:0]}};
            default: wdata_rep = req_wdata_i;
        endcase
    end

    dmem_sram #(.DEPTH(DEPTH), .AW(AW)) u_sram (
        .clk   (clk),
        .en    (accept && !err),
        .be    (be),
        .addr  (req_addr_i[AW+1:2]),
        .wdata (wdata_rep),
        .rdata (sram_rdata)
    );

    assign req_ready_o = !s1_valid_q || s1_go;
    assign accept      = req_valid_i && req_ready_o;
    assign s1_data     = (s1_valid_q && s1_load_q) ? load_extend(sram_rdata, s1_lane_q, s1_f3_q) : '0;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_err_d   = s1_err_q;
        s1_load_d  = s1_load_q;
        s1_lane_d  = s1_lane_q;
        s1_f3_d    = s1_f3_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_err_d   = err;
            s1_load_d  = !req_we_i && !err;
            s1_lane_d  = req_addr_i[1:0];
            s1_f3_d    = req_funct3_i;
        end else if (s1_go) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_load_q  <= 1'b0;
            s1_lane_q  <= '0;
            s1_f3_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_load_q  <= s1_load_d;
            s1_lane_q  <= s1_lane_d;
            s1_f3_q    <= s1_f3_d;
        end
    end

`ifdef DMEM_OUTREG_EN
    logic        s2_valid_q, s2_valid_d;
    logic        s2_err_q, s2_err_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic        s2_can_take;

    assign s2_can_take = !s2_valid_q || rsp_ready_i;
    assign s1_go       = s2_can_take;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_err_d   = s2_err_q;
        s2_data_d  = s2_data_q;
        if (s1_valid_q && s2_can_take) begin
            s2_valid_d = 1'b1;
            s2_err_d   = s1_err_q;
            s2_data_d  = s1_data;
        end else if (rsp_ready_i) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_err_q   <= s2_err_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign rsp_valid_o = s2_valid_q;
    assign rsp_rdata_o = s2_valid_q ? s2_data_q : '0;
    assign rsp_err_o   = s2_valid_q && s2_err_q;
`else
    assign s1_go       = rsp_ready_i;
    assign rsp_valid_o = s1_valid_q;
    assign rsp_rdata_o = s1_data;
    assign rsp_err_o   = s1_valid_q && s1_err_q;
`endif

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised byte-addressed RV32I data memory with an integrated load/store formatter.
- Accepts one load or store request per cycle over a valid/ready handshake.
- Returns one in-order response per request over a valid/ready handshake with backpressure.
- Handles LB/LH/LW/LBU/LHU/SB/SH/SW lane steering, sign/zero extension, and misaligned or out-of-range detection.
- Sits between the core's memory stage and the on-chip data SRAM.

Parameters:
- ADDR_W, 14: byte-address width of req_addr_i.
- DEPTH, 4096: number of 32-bit words. Must be ≤ 2**(ADDR_W-2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3 for the load/store.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_rdata_o  out  32  load result; 0 for stores and errors.
- rsp_err_o  out  1  misaligned, illegal funct3 or out-of-range.

Behaviour:
- Reset values: rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- Memory contents are not reset.
- Reset asserted mid-operation drops any pending response. Stores already committed stay in memory.
- Handshake and latency:
  - A request is accepted when req_valid_i && req_ready_o.
  - req_ready_o = !rsp_valid_o || rsp_ready_i, a single response slot.
  - The response appears 1 cycle after acceptance, so back-to-back throughput is 1 per cycle.
  - While rsp_valid_o && !rsp_ready_i, rsp_rdata_o and rsp_err_o hold stable and no request is accepted.
  - rsp_valid_o falls after a handshake unless a new request is accepted in the same cycle.
  - Request inputs are ignored when req_valid_i=0.
- Addressing:
  - Word index = req_addr_i[ADDR_W-1:2].
  - Lane = req_addr_i[1:0].
  - If word index ≥ DEPTH: err=1, no write.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value: err=1.
- Alignment:
  - Halfword with addr[0]=1 → err=1.
  - Word with addr[1:0]≠0 → err=1.
  - Any error: no memory write and rsp_rdata_o=0.
- Stores:
  - Byte enable is 0001 (SB), 0011 (SH) or 1111 (SW), shifted left by the lane.
  - Write data is replicated into all lanes: byte ×4, or half ×2.
  - Only enabled bytes change.
  - A store also returns a response: rdata=0, err as above.
- Loads:
  - The SRAM read is synchronous.
  - The raw word, lane and funct3 are registered. Extraction and extension are combinational from those registers, so the output is stable under stall.
  - LB/LH sign-extend. LBU/LHU zero-extend.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data. Requests are serialised, so there is no same-cycle conflict.

Optional Feature:
- Macro: DMEM_OUTREG_EN.
- Defined:
  - Adds a second pipeline register after extraction, giving 2-cycle latency with full 1/cycle throughput.
  - Each stage advances when the next stage is empty or draining.
  - req_ready_o = !s1_valid || s2_can_take.
  - Reset clears both stage valids.
  - Ordering is strictly preserved.
- Undefined: single-stage behaviour as above.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Size enum {SZ_B, SZ_H, SZ_W}.
  - Function be_mask(size, lane).
  - Function load_extend(word, lane, funct3).
- Sub-module dmem_sram:
  - DEPTH×32 byte-enabled synchronous RAM: clk, en, be[3:0], addr, wdata, rdata.
  - Read returns the old data on a simultaneous write.
  - No reset.

Test Plan:
- SW 0xDEADBEEF @0x010, then LW @0x010 → rsp_rdata_o=0xDEADBEEF, err=0, 1 cycle after accept.
- SB 0x80 @0x013, then LB @0x013 → 0xFFFFFF80; LBU @0x013 → 0x00000080; LW @0x010 → 0x80ADBEEF.
- LH @0x011 → err=1, rdata=0. SW @0x012 → err=1, and a following LW @0x010 is unchanged. funct3=011 load → err=1.
- Hold rsp_ready_i=0 for 3 cycles with LW pending → req_ready_o=0, rsp outputs stable. Release → next queued LW accepted in the same cycle.
- With DEPTH=1024, LW @0x1000 → err=1. Back-to-back 8 loads with rsp_ready_i=1 → 8 responses on consecutive cycles, in order.
- Assert rst_n=0 while rsp_valid_o=1 → rsp_valid_o=0 immediately, and the earlier store data is still readable after reset.
